// File: rtl/ldm_stm_seq.sv
// Block-transfer sequencer for LDM/STM: walks a 16-bit register list lowest-first,
// issuing one word access per memory handshake and producing the written-back base.
module ldm_stm_seq #(
  parameter int DATA_W     = 32,
  parameter int WORD_BYTES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              is_load,
  input  logic              up,
  input  logic              pre,
  input  logic [15:0]       reg_list,
  input  logic [DATA_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] wb_base,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [3:0]        rf_rd_addr,
  output logic              rf_w_en,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic [3:0]        rf_rm_addr,
  input  logic [DATA_W-1:0] rf_rm_data
);

  localparam logic [DATA_W-1:0] WB = DATA_W'(WORD_BYTES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_XFER  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              is_load_q, is_load_d;
  logic              up_q, up_d;
  logic              pre_q, pre_d;
  logic [15:0]       mask_q, mask_d;
  logic [DATA_W-1:0] wb_base_q, wb_base_d;
  logic [DATA_W-1:0] base_q, base_d;
  logic [DATA_W-1:0] addr_q, addr_d;

  logic [3:0]        cur;
  logic [DATA_W-1:0] span;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) c = c + {4'd0, v[i]};
    return c;
  endfunction

  function automatic logic [3:0] lowest_set(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) if (v[i]) idx = 4'(i);
    return idx;
  endfunction

  always_comb begin
    cur  = lowest_set(mask_q);
    span = DATA_W'(popcount16(mask_q)) * WB;
  end

  always_comb begin
    state_d    = state_q;
    is_load_d  = is_load_q;
    up_d       = up_q;
    pre_d      = pre_q;
    mask_d     = mask_q;
    wb_base_d  = wb_base_q;
    base_d     = base_q;
    addr_d     = addr_q;
    busy       = 1'b0;
    done       = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    rf_rd_addr = '0;
    rf_w_en    = 1'b0;
    rf_wr_data = '0;
    rf_rm_addr = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          is_load_d = is_load;
          up_d      = up;
          pre_d     = pre;
          mask_d    = reg_list;
          base_d    = base_addr;
          state_d   = S_SETUP;
        end
      end

      S_SETUP: begin
        busy = 1'b1;
        // Every mode transfers ascending; only the lowest address differs.
        if (up_q) begin
          wb_base_d = base_q + span;
          addr_d    = pre_q ? base_q + WB : base_q;
        end else begin
          wb_base_d = base_q - span;
          addr_d    = pre_q ? base_q - span : base_q - span + WB;
        end
        state_d = (mask_q == 16'd0) ? S_DONE : S_XFER;
      end

      S_XFER: begin
        busy     = 1'b1;
        mem_req  = 1'b1;
        mem_we   = ~is_load_q;
        mem_addr = addr_q;
        if (!is_load_q) begin
          rf_rm_addr = cur;
          mem_wdata  = rf_rm_data;
        end
        if (mem_ready) begin
          if (is_load_q) begin
            rf_w_en    = 1'b1;
            rf_rd_addr = cur;
            rf_wr_data = mem_rdata;
          end
          mask_d = mask_q & (mask_q - 16'd1);
          addr_d = addr_q + WB;
          if (mask_d == 16'd0) state_d = S_DONE;
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign wb_base = wb_base_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      is_load_q <= 1'b0;
      up_q      <= 1'b0;
      pre_q     <= 1'b0;
      mask_q    <= '0;
      wb_base_q <= '0;
    end else begin
      state_q   <= state_d;
      is_load_q <= is_load_d;
      up_q      <= up_d;
      pre_q     <= pre_d;
      mask_q    <= mask_d;
      wb_base_q <= wb_base_d;
    end
  end

  // Address datapath: never observed outside XFER, so it carries no reset.
  always_ff @(posedge clk) begin
    base_q <= base_d;
    addr_q <= addr_d;
  end

endmodule
